// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order word requests
// to instruction memory and buffers returned {pc, inst} pairs for the ID stage.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_target;
  logic          unused_bits;

  assign unused_bits     = ^redirect_pc[1:0];
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Every slot in the FIFO is reserved at request time, so a response can never overflow it.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign id_valid = (count_q != '0) && !redirect_valid;
  assign pop      = id_valid && id_ready;
  assign push     = imem_resp_valid && !redirect_valid && (drop_q == '0);
  assign id_pc    = pc_mem_q[rd_ptr_q];
  assign id_inst  = inst_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      outst_d    = outst_q - CW'(imem_resp_valid);
      drop_d     = outst_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count_q == CW'(DEPTH))));
      assert (!(imem_resp_valid && (outst_q == '0)));
    end
  end

endmodule
